// File: rtl/nn_pkg.sv
// Shared definitions for the nn layer sequencer and the config-word decoders.
// Field offsets locate the sub-fields of config word 0 so every decoder agrees.
package nn_pkg;

    localparam int NN_CFG_WIDTH = 16;
    localparam int NN_CFG_WORDS = 4;

    localparam int CFG0_MODE_LSB       = 0;
    localparam int CFG0_MODE_W         = 2;
    localparam int CFG0_POOL_BIT       = 2;
    localparam int CFG0_RELU_BIT       = 3;
    localparam int CFG0_STRIDE_LSB     = 4;
    localparam int CFG0_STRIDE_W       = 2;
    localparam int CFG0_PSUM_SHIFT_LSB = 8;
    localparam int CFG0_PSUM_SHIFT_W   = 5;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_START,
        SEQ_WAIT,
        SEQ_NEXT
    } nn_seq_state_t;

endpackage

// File: rtl/nn_cfg_bank.sv
// Layer descriptor storage: one synchronous word write port, asynchronous
// whole-slot read port. Contents are deliberately not reset.
module nn_cfg_bank
    import nn_pkg::*;
#(
    parameter int CFG_WIDTH       = NN_CFG_WIDTH,
    parameter int CFG_WORDS       = NN_CFG_WORDS,
    parameter int LAYER_DEPTH     = 8,
    parameter int CFG_ADDR_WIDTH  = $clog2(CFG_WORDS),
    parameter int LAYER_PTR_WIDTH = $clog2(LAYER_DEPTH)
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [LAYER_PTR_WIDTH-1:0]     wr_layer,
    input  logic [CFG_ADDR_WIDTH-1:0]      wr_addr,
    input  logic [CFG_WIDTH-1:0]           wr_data,
    input  logic [LAYER_PTR_WIDTH-1:0]     rd_layer,
    output logic [CFG_WORDS*CFG_WIDTH-1:0] rd_cfg
);

    logic [CFG_WIDTH-1:0] mem [LAYER_DEPTH][CFG_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_layer][wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_cfg = '0;
        for (int unsigned w = 0; w < CFG_WORDS; w++) begin
            rd_cfg[w*CFG_WIDTH +: CFG_WIDTH] = mem[rd_layer][w];
        end
    end

endmodule

// File: rtl/nn_layer_seq.sv
// Layer-descriptor sequencer: walks preloaded descriptors, starting the conv
// core for each and advancing on a rising edge of its finish signal.
module nn_layer_seq
    import nn_pkg::*;
#(
    parameter int CFG_WIDTH       = NN_CFG_WIDTH,
    parameter int CFG_WORDS       = NN_CFG_WORDS,
    parameter int LAYER_DEPTH     = 8,
    parameter int CFG_ADDR_WIDTH  = $clog2(CFG_WORDS),
    parameter int LAYER_PTR_WIDTH = $clog2(LAYER_DEPTH)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [CFG_WIDTH-1:0]           i_cfg,
    input  logic [CFG_ADDR_WIDTH-1:0]      i_cfg_addr,
    input  logic [LAYER_PTR_WIDTH-1:0]     i_cfg_layer,
    input  logic                           i_cfg_wr_en,
    input  logic                           i_run,
    input  logic [LAYER_PTR_WIDTH:0]       i_layer_cnt,
    input  logic                           i_loop,
    input  logic                           i_abort,
    input  logic                           i_core_finish,
    output logic [CFG_WORDS*CFG_WIDTH-1:0] o_cfg,
    output logic                           o_core_start,
    output logic [LAYER_PTR_WIDTH-1:0]     o_layer_idx,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_aborted,
    output logic                           o_wr_err
);

    localparam logic [LAYER_PTR_WIDTH:0]   DEPTH_CNT = LAYER_DEPTH;
    localparam logic [LAYER_PTR_WIDTH:0]   CNT_ONE   = 1;
    localparam logic [LAYER_PTR_WIDTH-1:0] IDX_ONE   = 1;

    nn_seq_state_t                state;
    logic [LAYER_PTR_WIDTH:0]     layer_cnt;
    logic [LAYER_PTR_WIDTH:0]     run_cnt;
    logic                         finish_prev;
    logic                         wr_conflict;
    logic [CFG_WORDS*CFG_WIDTH-1:0] slot_cfg;

    // The active slot is protected from host writes for the whole sequence;
    // the comparison uses the registered (pre-advance) index.
    assign wr_conflict = i_cfg_wr_en && o_busy && (i_cfg_layer == o_layer_idx);
    assign run_cnt     = (i_layer_cnt > DEPTH_CNT) ? DEPTH_CNT : i_layer_cnt;

    nn_cfg_bank #(
        .CFG_WIDTH       (CFG_WIDTH),
        .CFG_WORDS       (CFG_WORDS),
        .LAYER_DEPTH     (LAYER_DEPTH),
        .CFG_ADDR_WIDTH  (CFG_ADDR_WIDTH),
        .LAYER_PTR_WIDTH (LAYER_PTR_WIDTH)
    ) u_bank (
        .clk      (i_clk),
        .wr_en    (i_cfg_wr_en && !wr_conflict),
        .wr_layer (i_cfg_layer),
        .wr_addr  (i_cfg_addr),
        .wr_data  (i_cfg),
        .rd_layer (o_layer_idx),
        .rd_cfg   (slot_cfg)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= SEQ_IDLE;
            layer_cnt    <= '0;
            finish_prev  <= 1'b0;
            o_cfg        <= '0;
            o_core_start <= 1'b0;
            o_layer_idx  <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_aborted    <= 1'b0;
            o_wr_err     <= 1'b0;
        end else begin
            o_core_start <= 1'b0;
            o_done       <= 1'b0;
            o_aborted    <= 1'b0;
            if (wr_conflict) begin
                o_wr_err <= 1'b1;
            end

            if (state != SEQ_IDLE && i_abort) begin
                state     <= SEQ_IDLE;
                o_busy    <= 1'b0;
                o_aborted <= 1'b1;
            end else begin
                unique case (state)
                    SEQ_IDLE: begin
                        if (i_run) begin
                            if (i_layer_cnt == '0) begin
                                o_done <= 1'b1;
                            end else begin
                                layer_cnt   <= run_cnt;
                                o_layer_idx <= '0;
                                o_wr_err    <= 1'b0;
                                o_busy      <= 1'b1;
                                state       <= SEQ_LOAD;
                            end
                        end
                    end
                    SEQ_LOAD: begin
                        o_cfg        <= slot_cfg;
                        o_core_start <= 1'b1;
                        state        <= SEQ_START;
                    end
                    SEQ_START: begin
                        // Re-arm so a finish level left high by the previous layer is not an edge.
                        finish_prev <= i_core_finish;
                        state       <= SEQ_WAIT;
                    end
                    SEQ_WAIT: begin
                        finish_prev <= i_core_finish;
                        if (i_core_finish && !finish_prev) begin
                            state <= SEQ_NEXT;
                        end
                    end
                    SEQ_NEXT: begin
                        if (({1'b0, o_layer_idx} + CNT_ONE) < layer_cnt) begin
                            o_layer_idx <= o_layer_idx + IDX_ONE;
                            state       <= SEQ_LOAD;
                        end else if (i_loop) begin
                            o_layer_idx <= '0;
                            state       <= SEQ_LOAD;
                        end else begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= SEQ_IDLE;
                        end
                    end
                    default: begin
                        o_busy <= 1'b0;
                        state  <= SEQ_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
